// File: rtl/jt51_acc_pkg.sv
// Shared definitions for the channel accumulator: operator group encodings,
// per-algorithm carrier masks and output saturation limits.
package jt51_acc_pkg;

  typedef enum logic [1:0] {
    GRP_M1 = 2'd0,
    GRP_M2 = 2'd1,
    GRP_C1 = 2'd2,
    GRP_C2 = 2'd3
  } grp_e;

  // Index [con][grp]: bit set when that operator group is a carrier under the algorithm
  localparam logic [7:0][3:0] CARRIER_MASK = {
    4'b1111,  // con 7
    4'b1110,  // con 6
    4'b1110,  // con 5
    4'b1100,  // con 4
    4'b1000,  // con 3
    4'b1000,  // con 2
    4'b1000,  // con 1
    4'b1000   // con 0
  };

  localparam int OUTW_DEF = 16;
  localparam int SAT_MAX  = 32767;
  localparam int SAT_MIN  = -32768;

  function automatic logic is_carrier(input logic [2:0] con, input logic [1:0] grp);
    return CARRIER_MASK[con][grp];
  endfunction

endpackage

// File: rtl/jt51_acc_sat.sv
// Combinational signed saturation from an IW-bit mix value to an OW-bit sample.
module jt51_acc_sat #(
  parameter int IW = 19,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout
);

  localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  function automatic logic signed [OW-1:0] sat(input logic signed [IW-1:0] v);
    if (v > MAXV)
      return MAXV[OW-1:0];
    else if (v < MINV)
      return MINV[OW-1:0];
    else
      return v[OW-1:0];
  endfunction

  assign dout = sat(din);

endmodule

// File: rtl/jt51_opacc.sv
// Channel accumulator: sums carrier operators per channel across the 32-slot
// frame, mixes channels into L/R and emits one saturated stereo sample per frame.
module jt51_opacc
  import jt51_acc_pkg::*;
#(
  parameter int OPW  = 14,
  parameter int OUTW = 16,
  parameter int MIXW = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic                   zero,
  input  logic signed [OPW-1:0]  op_in,
  input  logic        [2:0]      con,
  input  logic        [1:0]      rl,
  output logic signed [OUTW-1:0] left,
  output logic signed [OUTW-1:0] right,
  output logic                   sample
);

  localparam int SW = OPW + 2;

  logic        [4:0]      cnt_q, cnt_d, slot;
  grp_e                   grp;
  logic        [2:0]      ch;
  logic signed [SW-1:0]   sum_q [8];
  logic signed [SW-1:0]   contrib, chan_total;
  logic signed [MIXW-1:0] mixl_q, mixr_q, mixl_d, mixr_d, total_ext;
  logic signed [OUTW-1:0] left_q, right_q, satl, satr;
  logic                   sample_q;

  // zero forces the current slot to 0; the register holds the slot expected next
  assign slot  = zero ? 5'd0 : cnt_q;
  assign cnt_d = slot + 5'd1;
  assign grp   = grp_e'(slot[4:3]);
  assign ch    = slot[2:0];

  assign contrib    = is_carrier(con, grp) ? {{(SW-OPW){op_in[OPW-1]}}, op_in} : '0;
  assign chan_total = sum_q[ch] + contrib;
  assign total_ext  = {{(MIXW-SW){chan_total[SW-1]}}, chan_total};

  assign mixl_d = mixl_q + ((rl[1] && grp == GRP_C2) ? total_ext : '0);
  assign mixr_d = mixr_q + ((rl[0] && grp == GRP_C2) ? total_ext : '0);

  jt51_acc_sat #(.IW(MIXW), .OW(OUTW)) u_sat_l (.din(mixl_d), .dout(satl));
  jt51_acc_sat #(.IW(MIXW), .OW(OUTW)) u_sat_r (.din(mixr_d), .dout(satr));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= 5'd0;
      mixl_q   <= '0;
      mixr_q   <= '0;
      left_q   <= '0;
      right_q  <= '0;
      sample_q <= 1'b0;
      for (int i = 0; i < 8; i++) sum_q[i] <= '0;
    end else begin
      sample_q <= 1'b0;
      if (cen) begin
        cnt_q <= cnt_d;
        case (grp)
          GRP_M1:         sum_q[ch] <= contrib;
          GRP_M2, GRP_C1: sum_q[ch] <= chan_total;
          default:        ;
        endcase
        // Slot 0 starts a fresh frame, dropping any partial mix left by a resync
        if (slot == 5'd0) begin
          mixl_q <= '0;
          mixr_q <= '0;
        end else if (grp == GRP_C2) begin
          mixl_q <= mixl_d;
          mixr_q <= mixr_d;
        end
        if (slot == 5'd31) begin
          left_q   <= satl;
          right_q  <= satr;
          sample_q <= 1'b1;
        end
      end
    end
  end

  assign left   = left_q;
  assign right  = right_q;
  assign sample = sample_q;

endmodule

// File: doc/jt51_opacc.md
Name: jt51_opacc

Overview:
- Channel accumulator directly downstream of the operator pipeline; consumes the 14-bit signed operator output, one operator per slot, 32 slots per sample.
- Sums the carrier operators of each of the 8 channels, selected by the channel's connection algorithm.
- Routes each channel total to the left and/or right mix according to its RL enables.
- Once per sample, emits saturated 16-bit left/right words with a one-cycle strobe.

Parameters:
- OPW, 14, operator sample width (signed).
- OUTW, 16, output sample width (signed, saturated).
- MIXW, 19, internal mix accumulator width; must be at least OPW+5.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- cen  in  1  clock enable; all state advances only when cen=1.
- zero  in  1  marks slot 0 (M1 of ch0) on op_in; resynchronises the slot counter.
- op_in  in  OPW  signed operator result for the current slot.
- con  in  3  connection algorithm of the channel owning the current slot.
- rl  in  2  bit1 = left enable, bit0 = right enable, for the current slot's channel.
- left  out  OUTW  signed left sample.
- right  out  OUTW  signed right sample.
- sample  out  1  new-sample strobe.

Behaviour:
- Slot counter (5 bits)
  - On a cen cycle: counter = 0 if zero=1, else counter+1; wraps 31->0.
  - Group g = slot[4:3], with 0=M1, 1=M2, 2=C1, 3=C2. Channel ch = slot[2:0].
- Carrier mask by con
  - con 0-3: C2 only.
  - con 4: C1 and C2.
  - con 5 and 6: M2, C1 and C2.
  - con 7: all four operators.
  - A non-carrier slot contributes 0.
- Per-channel sum: sum[ch], 8 entries of OPW+2 bits, signed, sign-extended adds.
  - g=0: sum[ch] <= contribution (overwrite, no add).
  - g=1 and g=2: sum[ch] <= sum[ch] + contribution.
  - g=3: chan_total = sum[ch] + contribution. This value is combinational and is never written back.
- Mix accumulators: mixL and mixR, MIXW bits each.
  - g=3: mixL += chan_total if rl[1]; mixR += chan_total if rl[0].
  - The slot-0 cen cycle clears both mixes, including when zero forces slot 0.
  - A zero arriving mid-frame therefore discards the partial frame, and no strobe is produced for it.
- Output, on the cen cycle of slot 31:
  - left <= sat(mixL + chan_total·rl[1]); right <= sat(mixR + chan_total·rl[0]).
  - sample <= 1.
- sat(): clamp to [-32768, 32767] for OUTW=16. Any value inside that range passes through unchanged.
- sample is high for exactly one clk cycle: it clears on the next clk edge regardless of cen. left/right hold their value until the next update.
- Latency: left/right are valid on the clk edge after the slot-31 cen cycle.
- The result reflects the con/rl values sampled in each contributing slot. Changing con mid-frame uses whichever mask is present per slot; this is not an error.
- Reset (rst_n=0 at a clk edge, regardless of cen)
  - Counter = 0; sum[] = 0; mixL = mixR = 0.
  - left = right = 0; sample = 0.
  - Reset applied mid-frame aborts the frame with no strobe.

Decomposition:
- Shared package/header jt51_acc_pkg:
  - Group encodings GRP_M1..GRP_C2.
  - Per-algorithm carrier-mask table (8×4 bits).
  - OUTW saturation limits.
- One sub-module, jt51_acc_sat: combinational signed saturation from MIXW to OUTW bits. It is instantiated twice, once for L and once for R.
- The slot counter and the sum[] register file stay inline.

Test Plan:
- Single carrier: con=0 on all channels, rl=2'b11, op_in=100 on C2 slots only, 0 elsewhere, frame starting at zero → after slot 31, left=right=800 and sample pulses once.
- con=7, ch0 only, all four ops=1000, rl=2'b10, other channels op_in=0 → left=4000, right=0; with con=4 instead → left=2000.
- Saturation:
  - con=7, every op = +8191, rl=11 → left=right=32767.
  - Every op = -8192 → left=right=-32768.
- Resync: assert zero at slot 17 mid-frame → no strobe at the old slot 31. The next strobe occurs 32 cen-cycles after the resync, and its values come from the new frame only.
- cen gating: cen high one clk in four over a full frame → identical outputs to the cen=1 run; sample width is exactly 1 clk.
- Reset: drop rst_n during slot 20, then release → left=right=0, sample=0. The first strobe comes only after a complete new frame.
